// File: rtl/local_history_bank.sv
// Per-branch local history table: a shift register of recent outcomes per PC index,
// cleared by a full-table sweep after reset or flush, with same-cycle update bypass.
module local_history_bank #(
    parameter int INDEX_BITS = 10,
    parameter int HIST_BITS  = 10,
    parameter int PC_SHIFT   = 0,
    parameter int NUM_RD     = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic [NUM_RD-1:0][31:0]          lookup_pc,
    output logic [NUM_RD-1:0][HIST_BITS-1:0] lookup_hist,
    output logic                             lookup_valid,
    input  logic                             upd_valid,
    input  logic [31:0]                      upd_pc,
    input  logic                             upd_taken,
    output logic                             upd_ready,
    output logic                             busy
);

    localparam int DEPTH = 1 << INDEX_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [INDEX_BITS-1:0]   cnt_reg;
    logic [INDEX_BITS-1:0]   cnt_next;

    logic [HIST_BITS-1:0]    table_mem [DEPTH];

    logic [INDEX_BITS-1:0]   upd_idx;
    logic                    upd_fire;
    logic [HIST_BITS-1:0]    upd_old;
    logic [HIST_BITS-1:0]    upd_new;
    logic                    unused_pc_bits;

    assign busy         = (state_reg == CLEAR);
    assign lookup_valid = (state_reg == READY);
    assign upd_ready    = lookup_valid && !flush;

    assign upd_idx  = upd_pc[PC_SHIFT +: INDEX_BITS];
    assign upd_fire = upd_valid && upd_ready;
    assign upd_old  = table_mem[upd_idx];

    // Newest outcome enters at the MSB; the oldest falls off the LSB.
    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign upd_new = upd_taken;
        end else begin : g_histn
            assign upd_new = {upd_taken, upd_old[HIST_BITS-1:1]};
        end
    endgenerate

    // PC bits outside the index field are deliberately ignored.
    assign unused_pc_bits = ^{upd_pc, lookup_pc};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                if (flush) begin
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == '1) begin
                        state_next = READY;
                    end
                end
            end
            READY: begin
                if (flush) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweep alone defines its contents.
    always_ff @(posedge clock) begin
        if (state_reg == CLEAR) begin
            table_mem[cnt_reg] <= '0;
        end else if (upd_fire) begin
            table_mem[upd_idx] <= upd_new;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [INDEX_BITS-1:0] rd_idx;
            assign rd_idx = lookup_pc[gi][PC_SHIFT +: INDEX_BITS];
            assign lookup_hist[gi] = busy ? '0 :
                                     (upd_fire && (rd_idx == upd_idx)) ? upd_new :
                                     table_mem[rd_idx];
        end
    endgenerate

endmodule

// File: tb/tb_local_history_bank.sv
// Bench for local_history_bank: a table-level model checked every cycle on a
// 1024-entry two-port instance, plus directed literal checks on a 16-entry aliasing instance.
module tb_local_history_bank;

    localparam int IB = 10;
    localparam int HB = 10;
    localparam int NR = 2;
    localparam int N  = 1 << IB;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  upd_valid = 1'b0;
    logic                  upd_taken = 1'b0;
    logic [31:0]           upd_pc = '0;
    logic [NR-1:0][31:0]   lookup_pc = '0;
    logic [NR-1:0][HB-1:0] lookup_hist;
    logic                  lookup_valid;
    logic                  upd_ready;
    logic                  busy;

    logic                  b_flush = 1'b0;
    logic                  b_upd_valid = 1'b0;
    logic                  b_upd_taken = 1'b0;
    logic [31:0]           b_upd_pc = '0;
    logic [0:0][31:0]      b_lookup_pc = '0;
    logic [0:0][HB-1:0]    b_hist;
    logic                  b_valid;
    logic                  b_ready;
    logic                  b_busy;

    int total = 0;
    int bad   = 0;

    local_history_bank #(.INDEX_BITS(IB), .HIST_BITS(HB), .PC_SHIFT(0), .NUM_RD(NR)) dut_a (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .lookup_pc(lookup_pc), .lookup_hist(lookup_hist), .lookup_valid(lookup_valid),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .busy(busy)
    );

    local_history_bank #(.INDEX_BITS(4), .HIST_BITS(HB), .PC_SHIFT(2), .NUM_RD(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .flush(b_flush),
        .lookup_pc(b_lookup_pc), .lookup_hist(b_hist), .lookup_valid(b_valid),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_taken(b_upd_taken),
        .upd_ready(b_ready), .busy(b_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a table of integers plus the number of sweep cycles still owed.
    int hist_m [N];
    int sweep_left = N;

    function automatic int model_next();
        return (upd_taken ? (1 << (HB - 1)) : 0) + hist_m[upd_pc & (N - 1)] / 2;
    endfunction

    function automatic int exp_hist(input logic [31:0] pc);
        if (sweep_left > 0) return 0;
        if (!flush && upd_valid && ((upd_pc & (N - 1)) == (pc & (N - 1)))) return model_next();
        return hist_m[pc & (N - 1)];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sweep_left <= N;
        end else if (sweep_left > 0) begin
            if (flush) begin
                sweep_left <= N;
            end else begin
                sweep_left <= sweep_left - 1;
                if (sweep_left == 1) begin
                    foreach (hist_m[i]) hist_m[i] <= 0;
                end
            end
        end else if (flush) begin
            sweep_left <= N;
        end else if (upd_valid) begin
            hist_m[upd_pc & (N - 1)] <= model_next();
        end
    end

    always @(negedge clock) begin
        chk("busy", busy, sweep_left > 0);
        chk("lookup_valid", lookup_valid, sweep_left == 0);
        chk("upd_ready", upd_ready, (sweep_left == 0) && !flush);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("hist_port%0d", p), lookup_hist[p], exp_hist(lookup_pc[p]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_sweep(input bit sel_b, input string nm, input int exp_len);
        int n = 0;
        for (int i = 0; i < 4 * N; i++) begin
            @(negedge clock);
            if (!(sel_b ? b_busy : busy)) break;
            n++;
        end
        chk(nm, n, exp_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        wait_sweep(0, "reset_sweep_len", N);
        chk("valid_after_sweep", lookup_valid, 1);
        chk("ready_after_sweep", upd_ready, 1);

        for (int i = 0; i < N; i++) begin
            tick();
            lookup_pc[0] = i;
            lookup_pc[1] = N - 1 - i;
        end

        // Alternating 1,0 x10 into one entry; neighbour stays zero.
        for (int k = 0; k < 10; k++) begin
            tick();
            upd_valid = 1'b1;
            upd_pc    = 32'h4D2;
            upd_taken = (k % 2 == 0);
            lookup_pc[0] = 32'h4D2;
            lookup_pc[1] = 32'h4D1;
        end
        tick();
        upd_valid = 1'b0;
        @(negedge clock);
        chk("shift_order", lookup_hist[0], 10'h155);
        chk("neighbour_zero", lookup_hist[1], 0);
        tick();
        lookup_pc[1] = 32'hABCD_E4D2;
        @(negedge clock);
        chk("alias_high_bits", lookup_hist[1], 10'h155);

        // 25 x (0,0,1) back-to-back; bypass shows each new value immediately.
        for (int k = 0; k < 75; k++) begin
            tick();
            upd_valid = 1'b1;
            upd_pc    = 32'h4D4;
            upd_taken = (k % 3 == 2);
            lookup_pc[0] = 32'h4D4;
            lookup_pc[1] = 32'h4D4;
            @(negedge clock);
            if (k == 2)  chk("bypass_first", lookup_hist[0], 10'h200);
            if (k == 74) chk("bypass_last", lookup_hist[1], 10'h249);
        end
        tick();
        upd_valid = 1'b0;
        @(negedge clock);
        chk("pattern_final", lookup_hist[0], 10'h249);

        // Flush with a pending update: update dropped, full sweep, table empty.
        tick();
        flush = 1'b1;
        upd_valid = 1'b1;
        upd_pc = 32'h4D2;
        upd_taken = 1'b1;
        lookup_pc[0] = 32'h4D2;
        @(negedge clock);
        chk("flush_upd_ready", upd_ready, 0);
        chk("flush_no_bypass", lookup_hist[0], 10'h155);
        tick();
        flush = 1'b0;
        upd_valid = 1'b0;
        @(negedge clock);
        chk("busy_after_flush", busy, 1);
        repeat (100) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_sweep(0, "flush_restart_len", N);
        tick();
        lookup_pc[0] = 32'h4D2;
        lookup_pc[1] = 32'h4D4;
        @(negedge clock);
        chk("flushed_4d2", lookup_hist[0], 0);
        chk("flushed_4d4", lookup_hist[1], 0);

        // Small instance: index = pc[5:2], so 0x04 and 0x44 share an entry.
        tick();
        b_upd_valid = 1'b1;
        b_upd_pc = 32'h04;
        b_upd_taken = 1'b1;
        tick();
        b_upd_pc = 32'h44;
        tick();
        b_upd_valid = 1'b0;
        b_lookup_pc[0] = 32'h04;
        @(negedge clock);
        chk("alias_0x04", b_hist[0], 10'h300);
        tick();
        b_lookup_pc[0] = 32'h44;
        @(negedge clock);
        chk("alias_0x44", b_hist[0], 10'h300);
        tick();
        b_flush = 1'b1;
        b_upd_valid = 1'b1;
        b_upd_pc = 32'h08;
        @(negedge clock);
        chk("b_flush_upd_ready", b_ready, 0);
        tick();
        b_flush = 1'b0;
        b_upd_valid = 1'b0;
        wait_sweep(1, "b_sweep_len", 16);
        chk("b_valid_after", b_valid, 1);
        for (int i = 0; i < 16; i++) begin
            tick();
            b_lookup_pc[0] = i << 2;
            @(negedge clock);
            chk($sformatf("b_clear_%0d", i), b_hist[0], 0);
        end

        // Reset pulse between edges in the middle of a sweep.
        for (int k = 0; k < 3; k++) begin
            tick();
            upd_valid = 1'b1;
            upd_pc = 32'h0D2;
            upd_taken = 1'b1;
        end
        tick();
        upd_valid = 1'b0;
        @(negedge clock);
        chk("pre_reset_value", lookup_hist[0], 10'h380);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (300) tick();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        wait_sweep(0, "reset_pulse_sweep_len", N);
        tick();
        lookup_pc[0] = 32'h0D2;
        lookup_pc[1] = 32'h0D2;
        @(negedge clock);
        chk("post_reset_zero", lookup_hist[0], 0);
        chk("ports_agree", lookup_hist[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/local_history_bank.md
LOCAL_HISTORY_BANK -- requirements
Module: local_history_bank

Interface
REQ-001 Parameter INDEX_BITS, default 10: table depth is 2**INDEX_BITS entries.
REQ-002 Parameter HIST_BITS, default 10: width of each history entry (legal 1..32).
REQ-003 Parameter PC_SHIFT, default 0: index = pc[PC_SHIFT +: INDEX_BITS].
REQ-004 Parameter NUM_RD, default 1: number of independent lookup ports (legal 1..4).
REQ-005 clock  in  1  single clock; all state changes on rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 flush  in  1  synchronous request to clear the whole table.
REQ-008 lookup_pc  in  NUM_RD x 32  per-port lookup PC.
REQ-009 lookup_hist  out  NUM_RD x HIST_BITS  per-port history, combinational from lookup_pc.
REQ-010 lookup_valid  out  1  high when table contents are valid (state READY).
REQ-011 upd_valid  in  1  update request.
REQ-012 upd_pc  in  32  PC of resolved branch.
REQ-013 upd_taken  in  1  resolved direction.
REQ-014 upd_ready  out  1  update accepted when upd_valid and upd_ready both high at a rising edge.
REQ-015 busy  out  1  high while a clear sweep is in progress.

Function
REQ-016 FSM states: CLEAR, READY; no other states are reachable.
REQ-017 CLEAR: sweep counter (INDEX_BITS wide) writes 0 to table[cnt] each cycle, increments by 1.
REQ-018 CLEAR -> READY on the edge that writes index 2**INDEX_BITS-1; the sweep takes exactly 2**INDEX_BITS cycles.
REQ-019 READY -> CLEAR, counter := 0, on any edge with flush=1; an update in the same cycle is dropped (upd_ready is low that cycle).
REQ-020 flush=1 during CLEAR restarts the counter at 0.
REQ-021 upd_ready = (state==READY) && !flush; lookup_valid = busy' = (state==READY); busy = (state==CLEAR).
REQ-022 Accepted update: table[idx] := {upd_taken, table[idx][HIST_BITS-1:1]} on the accepting edge (newest outcome in MSB, oldest dropped).
REQ-023 HIST_BITS=1: entry becomes upd_taken.
REQ-024 An update is visible to lookups in the cycle after acceptance; back-to-back updates to one index compound (no lost updates).
REQ-025 Same-cycle bypass: if a lookup index equals the accepted update index, lookup_hist returns the post-update value.
REQ-026 lookup_hist = 0 on every port while state==CLEAR, regardless of contents.
REQ-027 PC bits outside [PC_SHIFT +: INDEX_BITS] have no effect on indexing; aliasing PCs share one entry.
REQ-028 Ports are independent; identical indices on several ports return identical values.

Reset
REQ-029 reset_n=0 forces state := CLEAR and counter := 0 immediately, with no clock edge needed.
REQ-030 During reset and until the sweep completes: upd_ready=0, lookup_valid=0, busy=1, lookup_hist=0.
REQ-031 reset_n asserted mid-sweep or mid-operation restarts the full sweep after release; no partial table contents survive.
REQ-032 Table storage needs no reset of its own; its contents are defined only by the sweep.

Verification
REQ-033 Reset release, defaults: busy=1 for exactly 1024 cycles, then lookup_valid=1 and upd_ready=1; lookup_hist=0 for every index.
REQ-034 Shift order: 10 updates to pc=0x4D2, alternating taken=1,0 starting with 1 -> lookup_hist(0x4D2)=0x155; 0x4D1 unchanged at 0.
REQ-035 Pattern: 25x (0,0,1) to pc=0x4D4, back-to-back -> final value 0x249; bypass port shows each new value in the accepting cycle.
REQ-036 Alias: PC_SHIFT=2, INDEX_BITS=4; updates to pc=0x04 and 0x44 hit one entry; taken,taken -> 0x300.
REQ-037 Flush with upd_valid high in READY: update dropped, busy=1 next cycle, sweep of 2**INDEX_BITS cycles, all entries read 0 afterwards.
REQ-038 reset_n pulsed low for 3 ns mid-sweep (no edge): counter back to 0; full sweep repeats; NUM_RD=2 ports agree throughout.
